// File: rtl/stokes_integrator.sv
// stokes_integrator: per-channel I/Q/U/V accumulation over integ_len spectra, 3-clk pipelined RMW.
// Define STOKES_INTEG_SAT_EN to clamp overflowing sums instead of wrapping modulo 2^48.
module stokes_integrator #(
   parameter int BITWIDTH  = 7,
   parameter int FFT_POINT = 512,
   parameter int IN_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           integ_len,
   input  logic                  en_sync_in,
   input  logic [BITWIDTH+1:0]   cnt_sync_in,
   input  logic [IN_WIDTH-1:0]   stokes_in_I,
   input  logic [IN_WIDTH-1:0]   stokes_in_Q,
   input  logic [IN_WIDTH-1:0]   stokes_in_U,
   input  logic [IN_WIDTH-1:0]   stokes_in_V,
   output logic                  en_sync_out,
   output logic [BITWIDTH+1:0]   cnt_sync_out,
   output logic [47:0]           para_out_I0,
   output logic [47:0]           para_out_Q0,
   output logic [47:0]           para_out_U0,
   output logic [47:0]           para_out_V0,
   output logic                  integ_done,
   output logic                  sync_err,
   output logic                  ovf
);
   localparam int CW = BITWIDTH + 2;
   localparam logic [CW-1:0] LAST_IDX = CW'(FFT_POINT - 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   logic [0:0] state;
   logic [CW-1:0] exp_idx, a1, a2;
   logic [15:0] spec_cnt, len, cur_spec, cur_len;
   logic err, start, take, first, last;
   logic v1, v2, f1, f2, l1, l2, s1, s2;
   logic [3:0][IN_WIDTH-1:0] raw;
   logic [3:0][47:0] lane_sum;
   logic [3:0] lane_ovf;

   assign raw = {stokes_in_V, stokes_in_U, stokes_in_Q, stokes_in_I};

   // A mismatching index-0 beat both aborts the old integration and starts a new one.
   always_comb begin
      err      = en_sync_in && state == ACCUM && cnt_sync_in != exp_idx;
      start    = en_sync_in && cnt_sync_in == '0 && (state == IDLE || err);
      take     = start || (en_sync_in && state == ACCUM && !err);
      cur_spec = start ? 16'd0 : spec_cnt;
      cur_len  = start ? (integ_len == 16'd0 ? 16'd1 : integ_len) : len;
      first    = cur_spec == 16'd0;
      last     = cur_spec == cur_len - 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         exp_idx  <= '0;
         spec_cnt <= '0;
         len      <= 16'd1;
         sync_err <= 1'b0;
      end else begin
         sync_err <= err;
         if (take) begin
            len      <= cur_len;
            exp_idx  <= cnt_sync_in == LAST_IDX ? '0 : cnt_sync_in + 1'b1;
            spec_cnt <= cnt_sync_in == LAST_IDX ? cur_spec + 16'd1 : cur_spec;
            state    <= cnt_sync_in == LAST_IDX && last ? IDLE : ACCUM;
         end else if (err) begin
            state <= IDLE;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [47:0] ram [FFT_POINT];
      logic [47:0] x1, x2, rd1, rd2, s, nx;
      logic ov;
      always_ff @(posedge clk) begin
         x1  <= 48'($signed(raw[g]));
         x2  <= x1;
         rd1 <= ram[cnt_sync_in];
         rd2 <= rd1;
         if (v2) ram[a2] <= nx;
      end
      // First spectrum overwrites the bin, so stale RAM never needs clearing.
      always_comb begin
         s  = rd2 + x2;
         ov = !f2 && rd2[47] == x2[47] && s[47] != rd2[47];
`ifdef STOKES_INTEG_SAT_EN
         nx = f2 ? x2 : ov ? (rd2[47] ? {1'b1, 47'd0} : {1'b0, {47{1'b1}}}) : s;
`else
         nx = f2 ? x2 : s;
`endif
      end
      assign lane_sum[g] = nx;
      assign lane_ovf[g] = ov;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         {v1, v2, f1, f2, l1, l2, s1, s2} <= '0;
         a1           <= '0;
         a2           <= '0;
         en_sync_out  <= 1'b0;
         cnt_sync_out <= '0;
         para_out_I0  <= '0;
         para_out_Q0  <= '0;
         para_out_U0  <= '0;
         para_out_V0  <= '0;
         integ_done   <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         v1 <= take;
         f1 <= first;
         l1 <= last;
         s1 <= start;
         a1 <= cnt_sync_in;
         v2 <= v1;
         f2 <= f1;
         l2 <= l1;
         s2 <= s1;
         a2 <= a1;
         en_sync_out <= v2 && l2;
         integ_done  <= v2 && l2 && a2 == LAST_IDX;
         // Clearing travels with the start beat so older in-flight beats keep their flags.
         if (v2) ovf <= (ovf && !s2) || |lane_ovf;
         if (v2 && l2) begin
            cnt_sync_out <= a2;
            para_out_I0  <= lane_sum[0];
            para_out_Q0  <= lane_sum[1];
            para_out_U0  <= lane_sum[2];
            para_out_V0  <= lane_sum[3];
         end
      end
   end
endmodule
